// File: rtl/pcpi_mailbox_fifo.sv
// Bidirectional 6502<->Z80 mailbox built from two independent FWFT FIFOs.
// Optional sticky overflow flags are enabled by defining PCPI_MBOX_OVF_EN.

module pcpi_mailbox_fifo_chan #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              wr_stb_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_stb_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [AW:0]       cnt_o,
  output logic              drop_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              full_s, empty_s, push_ok_s, pop_ok_s;

  assign full_s  = (cnt_q == CNT_FULL);
  assign empty_s = (cnt_q == {(AW+1){1'b0}});
  // A full FIFO still accepts a push when a pop frees the head slot that same edge.
  assign push_ok_s = wr_stb_i & (~full_s | rd_stb_i);
  assign pop_ok_s  = rd_stb_i & ~empty_s;
  assign drop_o    = wr_stb_i & full_s & ~rd_stb_i;

  // Pointer and occupancy next-state
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_ok_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge clr_i) begin
    if (clr_i) begin
      wptr_q <= {AW{1'b0}};
      rptr_q <= {AW{1'b0}};
      cnt_q  <= {(AW+1){1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok_s && !clr_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty_s ? {DATA_W{1'b0}} : mem_q[rptr_q];
  assign cnt_o   = cnt_q;

endmodule

module pcpi_mailbox_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr_z80_data,
  input  logic              h_wr_stb,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_rd_stb,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              z_wr_stb,
  input  logic [DATA_W-1:0] z_wdata,
  input  logic              z_rd_stb,
  output logic [DATA_W-1:0] z_rdata,
  output logic              rdy_to80,
  output logic              rdy_to65,
  output logic              full_to80,
  output logic              full_to65,
  output logic [AW:0]       cnt_to80,
  output logic [AW:0]       cnt_to65,
  input  logic              ovf_clr,
  output logic              ovf_to80,
  output logic              ovf_to65,
  output logic              irq_n
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic drop_to80_s, drop_to65_s;

  pcpi_mailbox_fifo_chan #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_to80 (
    .clk      (clk),
    .clr_i    (clr_z80_data),
    .wr_stb_i (h_wr_stb),
    .wdata_i  (h_wdata),
    .rd_stb_i (z_rd_stb),
    .rdata_o  (z_rdata),
    .cnt_o    (cnt_to80),
    .drop_o   (drop_to80_s)
  );

  pcpi_mailbox_fifo_chan #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_to65 (
    .clk      (clk),
    .clr_i    (clr_z80_data),
    .wr_stb_i (z_wr_stb),
    .wdata_i  (z_wdata),
    .rd_stb_i (h_rd_stb),
    .rdata_o  (h_rdata),
    .cnt_o    (cnt_to65),
    .drop_o   (drop_to65_s)
  );

  assign rdy_to80  = (cnt_to80 != {(AW+1){1'b0}});
  assign rdy_to65  = (cnt_to65 != {(AW+1){1'b0}});
  assign full_to80 = (cnt_to80 == CNT_FULL);
  assign full_to65 = (cnt_to65 == CNT_FULL);

`ifdef PCPI_MBOX_OVF_EN
  logic ovf_to80_q, ovf_to80_d;
  logic ovf_to65_q, ovf_to65_d;

  // A drop in the same cycle as ovf_clr wins, so no overflow is ever lost
  always_comb begin
    ovf_to80_d = drop_to80_s | (ovf_to80_q & ~ovf_clr);
    ovf_to65_d = drop_to65_s | (ovf_to65_q & ~ovf_clr);
  end

  // Sticky overflow registers
  always_ff @(posedge clk or posedge clr_z80_data) begin
    if (clr_z80_data) begin
      ovf_to80_q <= 1'b0;
      ovf_to65_q <= 1'b0;
    end else begin
      ovf_to80_q <= ovf_to80_d;
      ovf_to65_q <= ovf_to65_d;
    end
  end

  assign ovf_to80 = ovf_to80_q;
  assign ovf_to65 = ovf_to65_q;
  assign irq_n    = ~(rdy_to80 | ovf_to80_q | ovf_to65_q);
`else
  logic ovf_inputs_unused;
  assign ovf_inputs_unused = ovf_clr | drop_to80_s | drop_to65_s;
  assign ovf_to80 = 1'b0;
  assign ovf_to65 = 1'b0;
  assign irq_n    = ~rdy_to80;
`endif

endmodule

// File: tb/tb_pcpi_mailbox_fifo.sv
// Directed self-checking bench for pcpi_mailbox_fifo (DATA_W=8, DEPTH=4).
// Expectations follow PCPI_MBOX_OVF_EN when it is defined for the build.
`timescale 1ns/1ps

module tb_pcpi_mailbox_fifo;

  logic       clk = 1'b0;
  logic       clr_z80_data;
  logic       h_wr_stb, h_rd_stb, z_wr_stb, z_rd_stb, ovf_clr;
  logic [7:0] h_wdata, z_wdata, h_rdata, z_rdata;
  logic       rdy_to80, rdy_to65, full_to80, full_to65;
  logic [2:0] cnt_to80, cnt_to65;
  logic       ovf_to80, ovf_to65, irq_n;

  int errors = 0;
  int checks = 0;

`ifdef PCPI_MBOX_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  pcpi_mailbox_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .clr_z80_data(clr_z80_data),
    .h_wr_stb(h_wr_stb), .h_wdata(h_wdata), .h_rd_stb(h_rd_stb), .h_rdata(h_rdata),
    .z_wr_stb(z_wr_stb), .z_wdata(z_wdata), .z_rd_stb(z_rd_stb), .z_rdata(z_rdata),
    .rdy_to80(rdy_to80), .rdy_to65(rdy_to65), .full_to80(full_to80), .full_to65(full_to65),
    .cnt_to80(cnt_to80), .cnt_to65(cnt_to65), .ovf_clr(ovf_clr),
    .ovf_to80(ovf_to80), .ovf_to65(ovf_to65), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  // One clock with the given strobes; inputs change and outputs are sampled 1ns after the edge
  task automatic cyc(input logic hw, input logic [7:0] hd, input logic hr,
                     input logic zw, input logic [7:0] zd, input logic zr, input logic oc);
    h_wr_stb = hw; h_wdata = hd; h_rd_stb = hr;
    z_wr_stb = zw; z_wdata = zd; z_rd_stb = zr; ovf_clr = oc;
    @(posedge clk); #1;
    h_wr_stb = 1'b0; h_rd_stb = 1'b0; z_wr_stb = 1'b0; z_rd_stb = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    clr_z80_data = 1'b1;
    @(posedge clk); #1;
    checks++; if (cnt_to80 !== 3'd0 || cnt_to65 !== 3'd0) begin errors++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt_to80, cnt_to65); end
    checks++; if ({rdy_to80, rdy_to65, full_to80, full_to65, ovf_to80, ovf_to65} !== 6'b0) begin errors++;
      $display("FAIL reset_flags got %b want 000000", {rdy_to80, rdy_to65, full_to80, full_to65, ovf_to80, ovf_to65}); end
    checks++; if (h_rdata !== 8'h00 || z_rdata !== 8'h00 || irq_n !== 1'b1) begin errors++;
      $display("FAIL reset_out got h=%h z=%h irq_n=%b want 00 00 1", h_rdata, z_rdata, irq_n); end
    clr_z80_data = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33;
    for (int i = 0; i < 3; i++) cyc(1'b1, exp_q[i], 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (cnt_to80 !== 3'd3 || rdy_to80 !== 1'b1 || z_rdata !== 8'h11) begin errors++;
      $display("FAIL basic_status got cnt=%0d rdy=%b head=%h want 3 1 11", cnt_to80, rdy_to80, z_rdata); end
    checks++; if (irq_n !== 1'b0) begin errors++;
      $display("FAIL basic_irq got %b want 0", irq_n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (z_rdata !== exp_q[i]) begin errors++;
        $display("FAIL basic_pop%0d got %h want %h", i, z_rdata, exp_q[i]); end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (rdy_to80 !== 1'b0 || z_rdata !== 8'h00 || irq_n !== 1'b1) begin errors++;
      $display("FAIL basic_empty got rdy=%b z=%h irq_n=%b want 0 00 1", rdy_to80, z_rdata, irq_n); end
    // popping an empty FIFO must leave it alone
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (cnt_to80 !== 3'd0) begin errors++;
      $display("FAIL basic_underflow got cnt=%0d want 0", cnt_to80); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    checks++; if (full_to65 !== 1'b1 || cnt_to65 !== 3'd4 || ovf_to65 !== 1'b0) begin errors++;
      $display("FAIL ovf_fill got full=%b cnt=%0d ovf=%b want 1 4 0", full_to65, cnt_to65, ovf_to65); end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b0);
    checks++; if (cnt_to65 !== 3'd4 || h_rdata !== 8'hA0) begin errors++;
      $display("FAIL ovf_drop got cnt=%0d head=%h want 4 a0", cnt_to65, h_rdata); end
    checks++; if (ovf_to65 !== OVF_ON || ovf_to80 !== 1'b0 || irq_n !== ~OVF_ON) begin errors++;
      $display("FAIL ovf_flag got ovf65=%b ovf80=%b irq_n=%b want %b 0 %b", ovf_to65, ovf_to80, irq_n, OVF_ON, ~OVF_ON); end
    // overflow again together with ovf_clr: the new overflow must keep the flag set
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    checks++; if (ovf_to65 !== OVF_ON) begin errors++;
      $display("FAIL ovf_clr_race got %b want %b", ovf_to65, OVF_ON); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (ovf_to65 !== 1'b0 || irq_n !== 1'b1) begin errors++;
      $display("FAIL ovf_clear got ovf=%b irq_n=%b want 0 1", ovf_to65, irq_n); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'hA1; exp_q[1] = 8'hA2; exp_q[2] = 8'hA3; exp_q[3] = 8'h55;
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    checks++; if (cnt_to65 !== 3'd4 || h_rdata !== 8'hA1 || ovf_to65 !== 1'b0) begin errors++;
      $display("FAIL fullpp got cnt=%0d head=%h ovf=%b want 4 a1 0", cnt_to65, h_rdata, ovf_to65); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (h_rdata !== exp_q[i]) begin errors++;
        $display("FAIL fullpp_drain%0d got %h want %h", i, h_rdata, exp_q[i]); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    checks++; if (rdy_to65 !== 1'b0 || h_rdata !== 8'h00) begin errors++;
      $display("FAIL fullpp_empty got rdy=%b h=%h want 0 00", rdy_to65, h_rdata); end
  endtask

  task automatic test_empty_pushpop();
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0);
    checks++; if (cnt_to65 !== 3'd1 || h_rdata !== 8'h7E || rdy_to65 !== 1'b1) begin errors++;
      $display("FAIL emptypp got cnt=%0d head=%h rdy=%b want 1 7e 1", cnt_to65, h_rdata, rdy_to65); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2 clr_z80_data = 1'b1;
    h_wr_stb = 1'b1; h_wdata = 8'hEE;
    #1;
    checks++; if (cnt_to80 !== 3'd0 || rdy_to80 !== 1'b0 || z_rdata !== 8'h00) begin errors++;
      $display("FAIL async_clr got cnt=%0d rdy=%b z=%h want 0 0 00", cnt_to80, rdy_to80, z_rdata); end
    @(posedge clk); #1;
    checks++; if (cnt_to80 !== 3'd0) begin errors++;
      $display("FAIL async_strobe_ignored got cnt=%0d want 0", cnt_to80); end
    h_wr_stb = 1'b0;
    clr_z80_data = 1'b0;
    cyc(1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (z_rdata !== 8'h42 || cnt_to80 !== 3'd1) begin errors++;
      $display("FAIL async_next got head=%h cnt=%0d want 42 1", z_rdata, cnt_to80); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] model_q [$];
    logic [7:0] nxt;
    model_q = {};
    for (int i = 0; i < 3; i++) begin
      nxt = 8'hC0 + 8'(i);
      cyc(1'b1, nxt, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      model_q.push_back(nxt);
    end
    // ten simultaneous push/pop pairs walk both pointers several times round
    for (int i = 0; i < 10; i++) begin
      nxt = 8'hD0 + 8'(i);
      checks++; if (z_rdata !== model_q[0]) begin errors++;
        $display("FAIL wrap_head%0d got %h want %h", i, z_rdata, model_q[0]); end
      cyc(1'b1, nxt, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      void'(model_q.pop_front());
      model_q.push_back(nxt);
      checks++; if (cnt_to80 !== 3'd3) begin errors++;
        $display("FAIL wrap_cnt%0d got %0d want 3", i, cnt_to80); end
    end
    while (model_q.size() > 0) begin
      checks++; if (z_rdata !== model_q[0]) begin errors++;
        $display("FAIL wrap_drain got %h want %h", z_rdata, model_q[0]); end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      void'(model_q.pop_front());
    end
  endtask

  task automatic test_both_fifos();
    cyc(1'b1, 8'h3C, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    checks++; if (z_rdata !== 8'h3C || h_rdata !== 8'hC3 || cnt_to80 !== 3'd1 || cnt_to65 !== 3'd1) begin errors++;
      $display("FAIL both_push got z=%h h=%h c80=%0d c65=%0d want 3c c3 1 1", z_rdata, h_rdata, cnt_to80, cnt_to65); end
    cyc(1'b1, 8'h5A, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
    checks++; if (z_rdata !== 8'h5A || h_rdata !== 8'hA5 || cnt_to80 !== 3'd1 || cnt_to65 !== 3'd1) begin errors++;
      $display("FAIL both_all4 got z=%h h=%h c80=%0d c65=%0d want 5a a5 1 1", z_rdata, h_rdata, cnt_to80, cnt_to65); end
  endtask

  initial begin
    clr_z80_data = 1'b1;
    h_wr_stb = 1'b0; h_rd_stb = 1'b0; z_wr_stb = 1'b0; z_rd_stb = 1'b0; ovf_clr = 1'b0;
    h_wdata = 8'h00; z_wdata = 8'h00;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_empty_pushpop();
    test_async_reset();
    test_wrap();
    test_both_fifos();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
